writeback_64: RTL and testbench

- Register-file and write-back stage of the 64-bit SEQ Y86 processor. It sits directly downstream of execute and memory, and upstream of decode.
- Holds the 15 architectural registers R[0..14] and commits valE and valM into them on each rising clock edge.
- Exports the whole register file so the decode stage can read valA and valB combinationally.
- Tracks the processor status code (stat), latches halt and error conditions, and counts retired instructions.

---
 rtl/writeback_64.sv | 52 +++++
 tb/tb_writeback_64.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/writeback_64.sv
// writeback_64: Y86-64 SEQ register file and write-back stage with status tracking
// and a retired-instruction counter.
module writeback_64 #(
  parameter int          NREG     = 15,
  parameter logic [3:0]  RNONE    = 4'hF,
  parameter logic [3:0]  RSP_ID   = 4'd4,
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           icode,
  input  logic                 cnd,
  input  logic [3:0]           rA,
  input  logic [3:0]           rB,
  input  logic [63:0]          valE,
  input  logic [63:0]          valM,
  input  logic                 mem_error,
  output logic [64*NREG-1:0]   reg_file,
  output logic [3:0]           dstE,
  output logic [3:0]           dstM,
  output logic [2:0]           stat,
  output logic [63:0]          retired
);
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  logic [63:0] r [NREG];
  logic        commit;
  always_comb begin
    dstE = (icode == 4'd2) ? (cnd ? rB : RNONE) :
           (icode == 4'd3 || icode == 4'd6) ? rB :
           (icode >= 4'd8 && icode <= 4'd11) ? RSP_ID : RNONE;
    dstM = (icode == 4'd5 || icode == 4'd11) ? rA : RNONE;
    commit = stat == AOK && !mem_error && icode <= 4'd11 && icode != 4'd0;
  end
  // valM is checked first so it wins when both ports target the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r[i] <= (4'(i) == RSP_ID) ? RSP_INIT : 64'd0;
      stat <= AOK;
      retired <= 64'd0;
    end else if (commit) begin
      for (int i = 0; i < NREG; i++)
        if (dstM == 4'(i)) r[i] <= valM;
        else if (dstE == 4'(i)) r[i] <= valE;
      retired <= retired + 64'd1;
    end else if (stat == AOK) begin
      stat <= mem_error ? ADR : (icode > 4'd11) ? INS : HLT;
    end
  end
  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_file[64*g +: 64] = r[g];
  end
endmodule

// File: tb/tb_writeback_64.sv
// tb_writeback_64: decode vector table, directed corner sequences and randomized
// traffic checked against a rule-level model of the write-back stage.
module tb_writeback_64;
  logic         clk = 0, rst = 1, cnd = 0, mem_error = 0;
  logic [3:0]   icode = 4'd1, rA = 4'hF, rB = 4'hF;
  logic [63:0]  valE = 0, valM = 0;
  logic [959:0] reg_file;
  logic [3:0]   dstE, dstM;
  logic [2:0]   stat;
  logic [63:0]  retired;
  int checks = 0, errors = 0;
  logic [63:0] m [15];
  logic [2:0]  mstat;
  logic [63:0] mret;

  writeback_64 #(.RSP_INIT(64'd512)) dut (
    .clk(clk), .rst(rst), .icode(icode), .cnd(cnd), .rA(rA), .rB(rB),
    .valE(valE), .valM(valM), .mem_error(mem_error), .reg_file(reg_file),
    .dstE(dstE), .dstM(dstM), .stat(stat), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ic; logic c; logic [3:0] a, b; logic [3:0] e_dstE, e_dstM;
  } dvec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] getr(input int i);
    return reg_file[64*i +: 64];
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic c, input logic [3:0] b);
    if (ic == 2) return c ? b : 4'hF;
    if (ic inside {4'd3, 4'd6}) return b;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] a);
    return (ic inside {4'd5, 4'd11}) ? a : 4'hF;
  endfunction

  task automatic check_state();
    for (int i = 0; i < 15; i++) chk($sformatf("R%0d", i), getr(i), m[i]);
    chk("stat", 64'(stat), 64'(mstat));
    chk("retired", retired, mret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    for (int i = 0; i < 15; i++) m[i] = (i == 4) ? 64'd512 : 64'd0;
    mstat = 1;
    mret = 0;
    @(negedge clk);
    rst = 0;
    check_state();
  endtask

  task automatic step(input logic [3:0] ic, input logic c, input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] e, input logic [63:0] mv, input logic me);
    logic [3:0] de, dm;
    icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = mv; mem_error = me;
    de = m_dstE(ic, c, b);
    dm = m_dstM(ic, a);
    #1;
    chk("dstE", 64'(dstE), 64'(de));
    chk("dstM", 64'(dstM), 64'(dm));
    @(posedge clk);
    if (mstat != 1) ;
    else if (me) mstat = 3;
    else if (ic > 11) mstat = 4;
    else if (ic == 0) mstat = 2;
    else begin
      if (de != 4'hF) m[de] = e;
      if (dm != 4'hF) m[dm] = mv;
      mret = mret + 1;
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    dvec_t tbl[$];
    tbl = '{
      '{4'd2, 1'b0, 4'd1, 4'd5, 4'hF, 4'hF},
      '{4'd2, 1'b1, 4'd1, 4'd5, 4'd5, 4'hF},
      '{4'd3, 1'b0, 4'hF, 4'd6, 4'd6, 4'hF},
      '{4'd6, 1'b1, 4'd2, 4'd7, 4'd7, 4'hF},
      '{4'd5, 1'b0, 4'd9, 4'd1, 4'hF, 4'd9},
      '{4'd8, 1'b0, 4'd3, 4'd3, 4'd4, 4'hF},
      '{4'd9, 1'b1, 4'd3, 4'd3, 4'd4, 4'hF},
      '{4'd10, 1'b0, 4'd8, 4'hF, 4'd4, 4'hF},
      '{4'd11, 1'b0, 4'd3, 4'hF, 4'd4, 4'd3},
      '{4'd4, 1'b1, 4'd3, 4'd2, 4'hF, 4'hF},
      '{4'd1, 1'b1, 4'd3, 4'd2, 4'hF, 4'hF},
      '{4'd0, 1'b1, 4'd3, 4'd2, 4'hF, 4'hF},
      '{4'd12, 1'b1, 4'd5, 4'd5, 4'hF, 4'hF},
      '{4'd7, 1'b1, 4'd5, 4'd5, 4'hF, 4'hF}
    };
    rst = 1;
    foreach (tbl[k]) begin
      icode = tbl[k].ic; cnd = tbl[k].c; rA = tbl[k].a; rB = tbl[k].b;
      #1;
      chk($sformatf("tbl%0d_dstE", k), 64'(dstE), 64'(tbl[k].e_dstE));
      chk($sformatf("tbl%0d_dstM", k), 64'(dstM), 64'(tbl[k].e_dstM));
    end

    do_reset();
    chk("rst_R4", getr(4), 64'd512);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_ret", retired, 64'd0);
    step(4'd3, 1'b0, 4'hF, 4'd2, 64'd777, 64'd0, 1'b0);
    chk("irmov_R2", getr(2), 64'd777);
    chk("irmov_ret", retired, 64'd1);
    step(4'd2, 1'b0, 4'hF, 4'd5, 64'd44, 64'd0, 1'b0);
    chk("cmov0_R5", getr(5), 64'd0);
    step(4'd2, 1'b1, 4'hF, 4'd5, 64'd44, 64'd0, 1'b0);
    chk("cmov1_R5", getr(5), 64'd44);
    step(4'd11, 1'b0, 4'd4, 4'hF, 64'd520, 64'd999, 1'b0);
    chk("poprsp_R4", getr(4), 64'd999);
    chk("poprsp_ret", retired, 64'd4);
    step(4'd11, 1'b0, 4'd3, 4'hF, 64'd520, 64'd666, 1'b0);
    chk("poprbx_R3", getr(3), 64'd666);
    chk("poprbx_R4", getr(4), 64'd520);
    step(4'd3, 1'b0, 4'hF, 4'hF, 64'd9, 64'd0, 1'b0);
    step(4'd1, 1'b0, 4'd2, 4'd2, 64'd1, 64'd1, 1'b0);
    step(4'd5, 1'b0, 4'd1, 4'd0, 64'd0, 64'd123, 1'b1);
    chk("adr_stat", 64'(stat), 64'd3);
    chk("adr_R1", getr(1), 64'd0);
    step(4'd3, 1'b0, 4'hF, 4'd6, 64'd55, 64'd0, 1'b0);
    chk("sticky_R6", getr(6), 64'd0);
    do_reset();
    chk("rst2_stat", 64'(stat), 64'd1);
    step(4'd0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
    chk("hlt_stat", 64'(stat), 64'd2);
    step(4'd3, 1'b0, 4'hF, 4'd6, 64'd55, 64'd0, 1'b0);
    chk("hlt_ret", retired, 64'd0);
    do_reset();
    step(4'd12, 1'b0, 4'd1, 4'd1, 64'd5, 64'd5, 1'b0);
    chk("ins_stat", 64'(stat), 64'd4);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(12, 15)) :
           ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
      step(ic, 1'($urandom), 4'($urandom), 4'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 49) == 0);
      if (mstat != 1 && $urandom_range(0, 2) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
